alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Upstream and downstream companion of the 4-bit combinational ALU. The block accepts 9-bit register-to-register instructions over a valid/ready handshake and reads two operands from an internal 4-entry x 4-bit register file. It drives the ALU operand and control inputs from registers, then captures the ALU result and writes it back to the destination register. It is the sequential datapath wrapper around the ALU in the Lab 8 datapath.

Parameters:
DATA_W, 4, operand/result width; must match ALU width
NREGS, 4, register file depth; register address width is fixed at 2 bits
CNT_W, 8, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction present
in_ready  output  1  sequencer can accept an instruction
in_instr  input  9  [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
alu_a  output  DATA_W  registered operand to ALU input1
alu_b  output  DATA_W  registered operand to ALU input2
alu_ctrl  output  3  registered op to ALU control
alu_result  input  DATA_W  combinational ALU output
done  output  1  one-cycle pulse on writeback
done_data  output  DATA_W  value written on writeback
dbg_addr  input  2  register file debug read address
dbg_data  output  DATA_W  combinational read of reg[dbg_addr]
retired  output  CNT_W  saturating count of completed instructions

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Register file all 0. alu_a=alu_b=0. alu_ctrl=000. done=0, done_data=0, retired=0. in_ready=1 once released.
- FSM states: IDLE, ISSUE, WB.
- IDLE: in_ready=1.
  - On in_valid: latch op/rd.
  - alu_a<=reg[rs1], alu_b<=reg[rs2], alu_ctrl<=op.
  - Go to ISSUE.
- ISSUE: in_ready=0. ALU settles combinationally. Go to WB.
- WB:
  - reg[rd]<=alu_result, done_data<=alu_result, done pulses for this cycle.
  - retired increments, saturating at all-ones.
  - in_ready=1. If in_valid, accept the next instruction exactly as in IDLE and go to ISSUE; otherwise go to IDLE.
- Latency: accept edge to done = 2 cycles.
- Throughput: one instruction per 2 cycles.
- Read-after-write: operands for an instruction accepted in WB are read from the register file as updated by that WB edge. The new value is forwarded when rs1/rs2 equals the rd being written, so there is no hazard.
- Handshake: transfer occurs only when in_valid && in_ready. in_instr is ignored otherwise. The sequencer never drops an accepted instruction.
- Ops are forwarded unmodified: 000 ADD, 001 SUB, 010 XOR, 011 OR, 100 AND, 101 NOR, 110 NAND, 111 XNOR.
- Arithmetic: the result is taken modulo 2^DATA_W. Carry/borrow is discarded.
- alu_a/alu_b/alu_ctrl hold their value between instructions.
- rd may equal rs1 or rs2. Operands are captured before writeback.
- Reset mid-operation: the in-flight instruction is abandoned with no writeback, and the register file is cleared.
- retired at all-ones stays at all-ones.

Optional Feature:
ALU_SEQ_FLAGS_EN:
- Defined: adds outputs flag_z (1) and flag_n (1), registered on each WB.
  - flag_z = (alu_result==0).
  - flag_n = alu_result[DATA_W-1].
  - Both reset to 0 and hold between writebacks.
- Undefined: these ports and registers do not exist.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_ADD..OP_XNOR), state enum (IDLE/ISSUE/WB), instruction field bit positions.
- One sub-module, alu_seq_regfile: 4x DATA_W registers, two combinational read ports plus the debug port, one write port, async clear.

Test Plan:
- Reset then instruction ADD r1=r0+r0 -> done pulses 2 cycles after accept, done_data=0, retired=1.
- Preload regs via SUB/XOR chain. Then ADD with r1=7, r2=12 into r3 -> done_data=3 (wrap), dbg_addr=3 gives 3.
- Back-to-back: XOR r2=r1^r1 accepted, next instr ADD r3=r2+r1 accepted in WB -> second operand sees r2=0, completes 2 cycles later, in_ready never low for more than 1 cycle.
- in_valid held while in ISSUE -> in_ready=0, instruction not consumed until WB, no duplicate writeback.
- Assert rst_n low during ISSUE -> all outputs 0 immediately, no done pulse, register file reads 0.
- Run 260 instructions -> retired saturates at 255. With ALU_SEQ_FLAGS_EN, SUB 0-1 gives flag_n=1, flag_z=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Contents:
//   OP_ADD..OP_XNOR     3-bit ALU control codes, passed through to the ALU unmodified
//   StIdle/StIssue/StWb sequencer FSM state encodings
//   instruction layout  [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2, with field extract helpers
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWb    = 2'd2;

  localparam int unsigned INSTR_W    = 9;
  localparam int unsigned REG_ADDR_W = 2;
  localparam int unsigned OP_LSB     = 6;
  localparam int unsigned RD_LSB     = 4;
  localparam int unsigned RS1_LSB    = 2;
  localparam int unsigned RS2_LSB    = 0;

  function automatic logic [2:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_LSB +: 3];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_LSB +: REG_ADDR_W];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
    return instr[RS1_LSB +: REG_ADDR_W];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] instr_rs2(input logic [INSTR_W-1:0] instr);
    return instr[RS2_LSB +: REG_ADDR_W];
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file for the ALU operation sequencer.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low clear of all entries
//   rd_addr_a/rd_data_a        combinational read port A (operand rs1)
//   rd_addr_b/rd_data_b        combinational read port B (operand rs2)
//   dbg_addr/dbg_data          combinational debug read port
//   we, wr_addr, wr_data       synchronous write port
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NREGS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequential wrapper around a 4-bit combinational ALU. Accepts register-to-register
// instructions over valid/ready, drives registered operands/control to the ALU, and
// writes the ALU result back into the register file two cycles after acceptance.
// Optional build macro ALU_SEQ_FLAGS_EN adds registered zero/negative flags.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     instruction handshake; in_instr = {op, rd, rs1, rs2}
//   alu_a, alu_b, alu_ctrl registered ALU inputs
//   alu_result            combinational ALU output
//   done, done_data       one-cycle writeback pulse and the value written
//   dbg_addr, dbg_data    combinational register file debug read
//   retired               saturating completed-instruction count
//   flag_z, flag_n        (ALU_SEQ_FLAGS_EN only) flags of the last writeback
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  done,
  output logic [DATA_W-1:0]     done_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [CNT_W-1:0]      retired
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                  flag_z,
  output logic                  flag_n
`endif
);

  logic [1:0]            state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     alu_a_q, alu_b_q, done_data_q;
  logic [2:0]            alu_ctrl_q;
  logic                  done_q;
  logic [CNT_W-1:0]      retired_q;

  logic                  wb, accept;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic [DATA_W-1:0]     rf_a, rf_b, opnd_a, opnd_b;

  assign wb       = (state_q == StWb);
  assign in_ready = (state_q != StIssue);
  assign accept   = in_valid && in_ready;
  assign rs1      = instr_rs1(in_instr);
  assign rs2      = instr_rs2(in_instr);

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rs1),
    .rd_data_a (rf_a),
    .rd_addr_b (rs2),
    .rd_data_b (rf_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .we        (wb),
    .wr_addr   (rd_q),
    .wr_data   (alu_result)
  );

  // An instruction accepted during WB must see the value being written on that same edge.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (wb && (rs1 == rd_q)) opnd_a = alu_result;
    if (wb && (rs2 == rd_q)) opnd_b = alu_result;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWb;
      StWb:    state_d = accept ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= wb;
      if (accept) begin
        rd_q       <= instr_rd(in_instr);
        alu_a_q    <= opnd_a;
        alu_b_q    <= opnd_b;
        alu_ctrl_q <= instr_op(in_instr);
      end
      if (wb) begin
        done_data_q <= alu_result;
        if (retired_q != '1) retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_z_q, flag_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (wb) begin
      flag_z_q <= (alu_result == '0);
      flag_n_q <= alu_result[DATA_W-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign done      = done_q;
  assign done_data = done_data_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural ALU feeds alu_result, and a
// register-array reference model predicts every writeback, register and counter value.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_instr = '0;
  logic [3:0] alu_a, alu_b, alu_result, done_data, dbg_data;
  logic [2:0] alu_ctrl;
  logic       done;
  logic [1:0] dbg_addr = '0;
  logic [7:0] retired;
`ifdef ALU_SEQ_FLAGS_EN
  logic       flag_z, flag_n;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [3:0] m_rf [4];
  int         m_ret;
  logic       m_z, m_n;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DATA_W (4),
    .NREGS  (4),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .done       (done),
    .done_data  (done_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .retired    (retired)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      OP_ADD:  r = (ai + bi) % 16;
      OP_SUB:  r = (ai - bi + 16) % 16;
      OP_XOR:  r = ai ^ bi;
      OP_OR:   r = ai | bi;
      OP_AND:  r = ai & bi;
      OP_NOR:  r = 15 - (ai | bi);
      OP_NAND: r = 15 - (ai & bi);
      default: r = 15 - (ai ^ bi);
    endcase
    return r[3:0];
  endfunction

  assign alu_result = alu_ref(alu_ctrl, alu_a, alu_b);

  function automatic logic [8:0] mk(input logic [2:0] op, input int rd, input int rs1,
                                    input int rs2);
    logic [1:0] d, s1, s2;
    d  = rd[1:0];
    s1 = rs1[1:0];
    s2 = rs2[1:0];
    return {op, d, s1, s2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_ret = 0;
    m_z   = 1'b0;
    m_n   = 1'b0;
  endtask

  task automatic model_exec(input logic [8:0] ins, output logic [3:0] res);
    logic [2:0] op;
    logic [1:0] rd, s1, s2;
    op  = ins[8:6];
    rd  = ins[5:4];
    s1  = ins[3:2];
    s2  = ins[1:0];
    res = alu_ref(op, m_rf[s1], m_rf[s2]);
    m_rf[rd] = res;
    if (m_ret < 255) m_ret++;
    m_z = (res == 4'd0);
    m_n = res[3];
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Presents one instruction; waited = negedges spent waiting for in_ready, -1 on timeout.
  task automatic send(input logic [8:0] ins, output int waited);
    waited = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 9'($urandom);
        waited   = i;
        break;
      end
      @(negedge clk);
    end
    if (waited < 0) in_valid = 1'b0;
  endtask

  // lat = negedges after the accept edge until done is seen, -1 on timeout.
  task automatic wait_done(output int lat, output logic [3:0] data);
    lat  = -1;
    data = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin
        lat  = i;
        data = done_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (alu_a !== 4'd0) $display("FAIL reset_alu_a: got %0h want 0", alu_a); else n_pass++;
    n_checks++; if (alu_b !== 4'd0) $display("FAIL reset_alu_b: got %0h want 0", alu_b); else n_pass++;
    n_checks++; if (alu_ctrl !== 3'd0) $display("FAIL reset_alu_ctrl: got %0h want 0", alu_ctrl); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
    n_checks++; if (done_data !== 4'd0) $display("FAIL reset_done_data: got %0h want 0", done_data); else n_pass++;
    n_checks++; if (retired !== 8'd0) $display("FAIL reset_retired: got %0d want 0", retired); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
`ifdef ALU_SEQ_FLAGS_EN
    n_checks++; if ({flag_z, flag_n} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {flag_z, flag_n}); else n_pass++;
`endif
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      n_checks++; if (dbg_data !== 4'd0) $display("FAIL reset_reg%0d: got %0h want 0", i, dbg_data); else n_pass++;
    end
  endtask

  task automatic test_first_add();
    logic [8:0] ins;
    logic [3:0] exp, d;
    int w, lat;
    ins = mk(OP_ADD, 1, 0, 0);
    model_exec(ins, exp);
    send(ins, w);
    n_checks++; if (w !== 0) $display("FAIL first_accept_wait: got %0d want 0", w); else n_pass++;
    wait_done(lat, d);
    n_checks++; if (lat !== 3) $display("FAIL first_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (d !== exp) $display("FAIL first_done_data: got %0h want %0h", d, exp); else n_pass++;
    n_checks++; if (retired !== 8'd1) $display("FAIL first_retired: got %0d want 1", retired); else n_pass++;
  endtask

  task automatic test_preload();
    logic [8:0] seq [8];
    logic [3:0] exp, d;
    int w, lat;
    seq[0] = mk(OP_NOR, 1, 0, 0);
    seq[1] = mk(OP_ADD, 2, 1, 1);
    seq[2] = mk(OP_SUB, 3, 0, 2);
    seq[3] = mk(OP_SUB, 2, 2, 3);
    seq[4] = mk(OP_ADD, 3, 3, 3);
    seq[5] = mk(OP_ADD, 3, 3, 3);
    seq[6] = mk(OP_XOR, 1, 1, 3);
    seq[7] = mk(OP_ADD, 3, 1, 2);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      model_exec(seq[i], exp);
      send(seq[i], w);
      wait_done(lat, d);
      n_checks++; if (lat !== 3) $display("FAIL preload_latency[%0d]: got %0d want 3", i, lat); else n_pass++;
      n_checks++; if (d !== exp) $display("FAIL preload_data[%0d]: got %0h want %0h", i, d, exp); else n_pass++;
    end
    // 7 + 12 wraps to 3
    n_checks++; if (d !== 4'd3) $display("FAIL preload_wrap_add: got %0h want 3", d); else n_pass++;
    dbg_addr = 2'd3;
    #1;
    n_checks++; if (dbg_data !== 4'd3) $display("FAIL preload_dbg_r3: got %0h want 3", dbg_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] i1, i2;
    logic [3:0] e1, e2;
    int w;
    i1 = mk(OP_XOR, 2, 1, 1);
    i2 = mk(OP_ADD, 3, 2, 1);
    model_exec(i1, e1);
    model_exec(i2, e2);
    send(i1, w);
    in_valid = 1'b1;
    in_instr = i2;
    @(negedge clk);
    n_checks++; if ({in_ready, done} !== 2'b00) $display("FAIL b2b_issue1: ready,done got %b want 00", {in_ready, done}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({in_ready, done} !== 2'b10) $display("FAIL b2b_wb1: ready,done got %b want 10", {in_ready, done}); else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({in_ready, done} !== 2'b01) $display("FAIL b2b_done1: ready,done got %b want 01", {in_ready, done}); else n_pass++;
    n_checks++; if (done_data !== e1) $display("FAIL b2b_data1: got %0h want %0h", done_data, e1); else n_pass++;
    @(negedge clk);
    n_checks++; if ({in_ready, done} !== 2'b10) $display("FAIL b2b_wb2: ready,done got %b want 10", {in_ready, done}); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL b2b_done2: got %0b want 1", done); else n_pass++;
    n_checks++; if (done_data !== e2) $display("FAIL b2b_data2_raw: got %0h want %0h", done_data, e2); else n_pass++;
  endtask

  task automatic test_hold_in_issue();
    logic [8:0] i1, i2;
    logic [3:0] e1, e2;
    logic [3:0] got [2];
    int ndone;
    i1 = mk(OP_ADD, 1, 1, 3);
    i2 = mk(OP_SUB, 0, 1, 2);
    model_exec(i1, e1);
    model_exec(i2, e2);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = i1;
    @(posedge clk);
    #1;
    in_instr = i2;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL hold_issue_ready: got %0b want 0", in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL hold_wb_ready: got %0b want 1", in_ready); else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ndone  = 0;
    got[0] = '0;
    got[1] = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 2) got[ndone] = done_data;
        ndone++;
      end
    end
    n_checks++; if (ndone !== 2) $display("FAIL hold_done_count: got %0d want 2", ndone); else n_pass++;
    n_checks++; if (got[0] !== e1) $display("FAIL hold_data1: got %0h want %0h", got[0], e1); else n_pass++;
    n_checks++; if (got[1] !== e2) $display("FAIL hold_data2: got %0h want %0h", got[1], e2); else n_pass++;
    n_checks++; if (retired !== 8'(m_ret)) $display("FAIL hold_retired: got %0d want %0d", retired, m_ret); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      n_checks++; if (dbg_data !== m_rf[i]) $display("FAIL hold_reg%0d: got %0h want %0h", i, dbg_data, m_rf[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [8:0] ins;
    logic [3:0] exp, d;
    int w, lat;
    for (int n = 0; n < 40; n++) begin
      ins = 9'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_exec(ins, exp);
      send(ins, w);
      wait_done(lat, d);
      n_checks++; if (lat !== 3) $display("FAIL rand_latency[%0d]: got %0d want 3", n, lat); else n_pass++;
      n_checks++; if (d !== exp) $display("FAIL rand_data[%0d] instr %03h: got %0h want %0h", n, ins, d, exp); else n_pass++;
`ifdef ALU_SEQ_FLAGS_EN
      n_checks++; if ({flag_z, flag_n} !== {m_z, m_n}) $display("FAIL rand_flags[%0d]: got %b want %b", n, {flag_z, flag_n}, {m_z, m_n}); else n_pass++;
`endif
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      n_checks++; if (dbg_data !== m_rf[i]) $display("FAIL rand_reg%0d: got %0h want %0h", i, dbg_data, m_rf[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int w, ndone;
    send(mk(OP_NOR, 2, 0, 1), w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({alu_a, alu_b, alu_ctrl} !== 11'd0) $display("FAIL midrst_alu_in: got %h want 0", {alu_a, alu_b, alu_ctrl}); else n_pass++;
    n_checks++; if ({done, done_data} !== 5'd0) $display("FAIL midrst_done: got %h want 0", {done, done_data}); else n_pass++;
    n_checks++; if (retired !== 8'd0) $display("FAIL midrst_retired: got %0d want 0", retired); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      n_checks++; if (dbg_data !== 4'd0) $display("FAIL midrst_reg%0d: got %0h want 0", i, dbg_data); else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_checks++; if (ndone !== 0) $display("FAIL midrst_no_wb: got %0d done pulses want 0", ndone); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [8:0] ins;
    logic [3:0] exp, d;
    int w, lat;
    for (int n = 0; n < 260; n++) begin
      ins = 9'($urandom);
      model_exec(ins, exp);
      send(ins, w);
      wait_done(lat, d);
      n_checks++; if (d !== exp) $display("FAIL sat_data[%0d]: got %0h want %0h", n, d, exp); else n_pass++;
      n_checks++; if (retired !== 8'(m_ret)) $display("FAIL sat_retired[%0d]: got %0d want %0d", n, retired, m_ret); else n_pass++;
    end
    n_checks++; if (retired !== 8'd255) $display("FAIL sat_final: got %0d want 255", retired); else n_pass++;
  endtask

`ifdef ALU_SEQ_FLAGS_EN
  task automatic test_flags();
    logic [8:0] seq [4];
    logic [3:0] exp, d;
    int w, lat;
    do_reset();
    seq[0] = mk(OP_NOR, 1, 0, 0);
    seq[1] = mk(OP_SUB, 2, 0, 1);
    seq[2] = mk(OP_SUB, 3, 0, 2);
    seq[3] = mk(OP_XOR, 3, 3, 3);
    for (int i = 0; i < 4; i++) begin
      model_exec(seq[i], exp);
      send(seq[i], w);
      wait_done(lat, d);
      n_checks++; if (d !== exp) $display("FAIL flags_data[%0d]: got %0h want %0h", i, d, exp); else n_pass++;
      n_checks++; if ({flag_z, flag_n} !== {m_z, m_n}) $display("FAIL flags[%0d]: got %b want %b", i, {flag_z, flag_n}, {m_z, m_n}); else n_pass++;
      if (i == 2) begin
        n_checks++; if ({flag_z, flag_n} !== 2'b01) $display("FAIL flags_sub_0_1: got %b want 01", {flag_z, flag_n}); else n_pass++;
      end
    end
    repeat (3) @(negedge clk);
    n_checks++; if ({flag_z, flag_n} !== 2'b10) $display("FAIL flags_hold: got %b want 10", {flag_z, flag_n}); else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_first_add();
    test_preload();
    test_back_to_back();
    test_hold_in_issue();
    test_random();
    test_reset_mid();
    test_saturation();
`ifdef ALU_SEQ_FLAGS_EN
    test_flags();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
